// File: rtl/berger_scrub_controller_if.sv
// Memory-side request/grant/read port shared between the scrubber and the arbiter.
interface berger_scrub_controller_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CHK_W  = 4
);
    logic                    mem_req;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [DATA_W+CHK_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/berger_scrub_controller.sv
// Background Berger-code scrubber: reads every word once per pass and flags zero-count mismatches.
// Optional macro BERGER_SCRUB_HALT_ON_ERR_EN ends the pass at the first failing word.
module berger_scrub_controller #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CHK_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    berger_scrub_controller_if.master mem,
    output logic                      busy,
    output logic                      done,
    output logic                      err_valid,
    output logic [ADDR_W-1:0]         err_addr,
    output logic [CNT_W-1:0]          err_count
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              err_valid_q, err_valid_d;
    logic              done_q, done_d;
    logic              word_bad;
    logic              last_word;

    function automatic logic [CHK_W-1:0] zero_count(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] n;
        n = CHK_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) n = n - CHK_W'(d[i]);
        return n;
    endfunction

    // The check result is what gets registered on the returning read, so err_valid,
    // err_addr and err_count are all flops that present during the CHECK cycle.
    assign word_bad = zero_count(mem.mem_rdata[DATA_W+CHK_W-1:CHK_W]) != mem.mem_rdata[CHK_W-1:0];

`ifdef BERGER_SCRUB_HALT_ON_ERR_EN
    assign last_word = err_valid_q || (addr_q == '1);
`else
    assign last_word = (addr_q == '1);
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        err_valid_d = 1'b0;
        done_d      = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_REQ;
                        addr_d      = '0;
                        err_count_d = '0;
                    end
                end
                S_REQ: begin
                    if (mem.mem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mem.mem_rvalid) begin
                        state_d = S_CHECK;
                        if (word_bad) begin
                            err_valid_d = 1'b1;
                            err_addr_d  = addr_q;
                            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (last_word) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            err_addr_q  <= '0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            err_valid_q <= err_valid_d;
            done_q      <= done_d;
        end
    end

    assign mem.mem_req  = (state_q == S_REQ);
    assign mem.mem_addr = addr_q;
    assign busy         = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done         = done_q;
    assign err_valid    = err_valid_q;
    assign err_addr     = err_addr_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_berger_scrub_controller.sv
// Randomized self-checking bench for berger_scrub_controller against a pass-level reference model.
module tb_berger_scrub_controller;
    localparam int ADDR_W = 6, DATA_W = 8, CHK_W = 4, CNT_W = 8;
    localparam int DEPTH = 1 << ADDR_W, W = DATA_W + CHK_W;
    localparam int S_ADDR_W = 9, S_DEPTH = 1 << S_ADDR_W, S_BAD = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic busy, done, err_valid;
    logic [ADDR_W-1:0] err_addr;
    logic [CNT_W-1:0]  err_count;
    logic s_start = 1'b0, s_abort = 1'b0;
    logic s_busy, s_done, s_err_valid;
    logic [S_ADDR_W-1:0] s_err_addr;
    logic [CNT_W-1:0]    s_err_count;

    berger_scrub_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHK_W(CHK_W)) mi();
    berger_scrub_controller_if #(.ADDR_W(S_ADDR_W), .DATA_W(DATA_W), .CHK_W(CHK_W)) si();

    berger_scrub_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHK_W(CHK_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mem(mi), .busy(busy), .done(done),
        .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count));

    berger_scrub_controller #(.ADDR_W(S_ADDR_W), .DATA_W(DATA_W), .CHK_W(CHK_W), .CNT_W(CNT_W)) sat_dut (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .mem(si), .busy(s_busy), .done(s_done),
        .err_valid(s_err_valid), .err_addr(s_err_addr), .err_count(s_err_count));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: a word is bad when DATA_W minus its ones count differs from its check field.
    function automatic bit word_bad(input logic [W-1:0] w);
        int z;
        z = DATA_W;
        for (int i = CHK_W; i < W; i++) z -= int'(w[i]);
        return z != int'(w[CHK_W-1:0]);
    endfunction

    function automatic logic [W-1:0] good_word(input logic [DATA_W-1:0] d);
        int z;
        z = DATA_W - $countones(d);
        return {d, CHK_W'(z)};
    endfunction

    logic [W-1:0] mem [DEPTH];
    int gnt_hold [DEPTH];
    int lat [DEPTH];
    int req_cyc [DEPTH];
    bit spur_en = 1'b0;

    int acc_q[$], got_err[$];
    int done_cnt = 0, done_cyc = 0, addr_jumps = 0;
    int lat_cnt = 0, hold_cnt = 0;
    bit prev_req = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0, pend_addr = '0;

    // Memory/arbiter model for the main DUT plus passive monitoring of its outputs.
    always @(negedge clk) begin
        if (rst) begin
            lat_cnt = 0; prev_req = 1'b0; hold_cnt = 0;
            mi.mem_gnt = 1'b0; mi.mem_rvalid = 1'b0; mi.mem_rdata = '0;
        end else begin
            if (err_valid) got_err.push_back(int'(err_addr));
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (mi.mem_req) req_cyc[mi.mem_addr]++;
            if (mi.mem_req && prev_req && mi.mem_addr != prev_addr) addr_jumps++;
            mi.mem_rvalid = 1'b0;
            mi.mem_rdata = W'($urandom);
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin mi.mem_rvalid = 1'b1; mi.mem_rdata = mem[pend_addr]; end
            end
            if (spur_en && mi.mem_req && !mi.mem_rvalid && $urandom_range(0, 3) == 0) begin
                mi.mem_rvalid = 1'b1; mi.mem_rdata = 12'h001;
            end
            mi.mem_gnt = 1'b0;
            if (mi.mem_req) begin
                if (!prev_req) hold_cnt = gnt_hold[mi.mem_addr];
                if (hold_cnt > 0) hold_cnt--;
                else begin
                    mi.mem_gnt = 1'b1;
                    acc_q.push_back(int'(mi.mem_addr));
                    pend_addr = mi.mem_addr;
                    lat_cnt = lat[mi.mem_addr];
                end
            end
            prev_req = mi.mem_req && !mi.mem_gnt;
            prev_addr = mi.mem_addr;
        end
    end

    bit s_pend = 1'b0;
    logic [S_ADDR_W-1:0] s_pend_addr = '0;
    int s_done_cnt = 0, s_err_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            s_pend = 1'b0; si.mem_gnt = 1'b0; si.mem_rvalid = 1'b0; si.mem_rdata = '0;
        end else begin
            if (s_done) s_done_cnt++;
            if (s_err_valid) s_err_cnt++;
            si.mem_rvalid = s_pend;
            si.mem_rdata = (int'(s_pend_addr) < S_BAD) ? 12'h001 : 12'h008;
            si.mem_gnt = 1'b1;
            s_pend = si.mem_req;
            s_pend_addr = si.mem_addr;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic fill_clean();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = good_word(DATA_W'($urandom));
            gnt_hold[i] = 0;
            lat[i] = 1;
        end
    endtask

    task automatic clear_mon();
        acc_q.delete(); got_err.delete();
        done_cnt = 0; addr_jumps = 0;
        for (int i = 0; i < DEPTH; i++) req_cyc[i] = 0;
    endtask

    int exp_err_addr = 0;

    task automatic run_pass(input string tag, input bit chk_time);
        int exp_err[$];
        int n_reads, exp_cnt, exp_last, s_cyc, k, bad;
        for (int i = 0; i < DEPTH; i++) if (word_bad(mem[i])) exp_err.push_back(i);
        n_reads = DEPTH;
        exp_last = DEPTH - 1;
`ifdef BERGER_SCRUB_HALT_ON_ERR_EN
        if (exp_err.size() > 0) begin
            n_reads = exp_err[0] + 1;
            exp_last = exp_err[0];
            exp_err = '{exp_err[0]};
        end
`endif
        exp_cnt = (exp_err.size() > 255) ? 255 : exp_err.size();
        if (exp_err.size() > 0) exp_err_addr = exp_err[exp_err.size()-1];
        clear_mon();
        start = 1'b1; s_cyc = cyc;
        tick();
        start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin tick(); k++; end
        chk({tag, " timeout"}, k < 3000, 1);
        if (chk_time) chk({tag, " done_cycle"}, done_cyc - s_cyc + 1, 194);
        tick(3);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " reads"}, acc_q.size(), n_reads);
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] != i) bad++;
        chk({tag, " read_order"}, bad, 0);
        chk({tag, " err_pulses"}, got_err.size(), exp_err.size());
        bad = 0;
        foreach (got_err[i]) if (i >= exp_err.size() || got_err[i] != exp_err[i]) bad++;
        chk({tag, " err_addrs"}, bad, 0);
        chk({tag, " err_count"}, err_count, exp_cnt);
        chk({tag, " err_addr"}, err_addr, exp_err_addr);
        chk({tag, " mem_addr"}, mi.mem_addr, exp_last);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " addr_stable"}, addr_jumps, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < DEPTH; i++) begin gnt_hold[i] = 0; lat[i] = 1; req_cyc[i] = 0; end
        tick(2);
        chk("rst mem_req", mi.mem_req, 0);
        chk("rst mem_addr", mi.mem_addr, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err_valid", err_valid, 0);
        chk("rst err_addr", err_addr, 0);
        chk("rst err_count", err_count, 0);
        rst = 1'b0;
        tick(2);

        fill_clean();
        mem[0] = 12'hA54; mem[1] = 12'hFF0; mem[2] = 12'h008;
        run_pass("clean", 1'b1);

        fill_clean();
        mem[5] = 12'hA55; mem[40] = 12'h001;
        run_pass("two_err", 1'b0);

        fill_clean();
        gnt_hold[3] = 4;
        run_pass("gnt_hold", 1'b0);
        chk("gnt_hold req_cycles", req_cyc[3], 5);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = ($urandom_range(0, 5) == 0) ? W'($urandom) : good_word(DATA_W'($urandom));
                gnt_hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                lat[i] = $urandom_range(1, 3);
            end
            spur_en = 1'b1;
            run_pass($sformatf("rand%0d", p), 1'b0);
            spur_en = 1'b0;
        end

        // Abort while waiting for read data at address 10; the late data must be dropped.
        fill_clean();
        mem[10] = 12'h001;
        lat[10] = 3;
        clear_mon();
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (acc_q.size() < 11 && k < 200) begin tick(); k++; end
        chk("abort reach_addr10", k < 200, 1);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort mem_req", mi.mem_req, 0);
        tick(6);
        chk("abort no_done", done_cnt, 0);
        chk("abort late_rvalid", got_err.size(), 0);
        chk("abort err_count", err_count, 0);
        chk("abort err_addr", err_addr, exp_err_addr);

        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        tick();
        chk("abort_beats_start busy", busy, 0);

        // Asynchronous reset in the middle of a pass.
        fill_clean();
        mem[2] = 12'h001;
        start = 1'b1; tick(); start = 1'b0;
        tick(20);
        chk("midrst err_addr_before", err_addr, 2);
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst mem_req", mi.mem_req, 0);
        chk("midrst mem_addr", mi.mem_addr, 0);
        chk("midrst err_addr", err_addr, 0);
        chk("midrst err_count", err_count, 0);
        exp_err_addr = 0;
        tick(2);
        rst = 1'b0;
        tick(2);

        // Saturation on the 512-word instance with 300 corrupted words.
        s_start = 1'b1; tick(); s_start = 1'b0;
        k = 0;
        while (s_done_cnt == 0 && k < 3000) begin tick(); k++; end
        chk("sat timeout", k < 3000, 1);
`ifdef BERGER_SCRUB_HALT_ON_ERR_EN
        chk("sat err_count", s_err_count, 1);
        chk("sat err_addr", s_err_addr, 0);
`else
        chk("sat err_count", s_err_count, 255);
        chk("sat err_pulses", s_err_cnt, S_BAD);
        chk("sat err_addr", s_err_addr, S_BAD - 1);
`endif
        tick(2);
        s_start = 1'b1; tick(); s_start = 1'b0;
        tick();
        chk("sat restart_clear", s_err_count, 0);
        s_abort = 1'b1; tick(); s_abort = 1'b0;
        chk("sat abort busy", s_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/berger_scrub_controller.md
Name: berger_scrub_controller

Overview:
Background scrubber for a Berger-coded memory holding DATA_W data bits plus a CHK_W zero-count check field. On start, it walks every address from 0 to DEPTH-1 and issues one read per address through a request/grant port shared with the host. It then recomputes the zero count and reports each mismatching address, along with a saturating error tally. It sits beside the memory arbiter as a low-priority requester.

Parameters:
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words scanned per pass
DATA_W, 8, data bits per word
CHK_W, 4, check-field width; must hold DATA_W (4 for 8 data bits)
CNT_W, 8, width of the error counter

Ports:
clk  input  1  clock, all state changes on the rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a pass; ignored unless in IDLE
abort  input  1  level; forces return to IDLE
mem_req  output  1  read request to the arbiter
mem_addr  output  ADDR_W  address being scrubbed
mem_gnt  input  1  arbiter grant; a read is accepted in a cycle with mem_req & mem_gnt
mem_rvalid  input  1  read data valid, at earliest 1 cycle after the accepting grant
mem_rdata  input  DATA_W+CHK_W  code word: [DATA_W+CHK_W-1:CHK_W] data, [CHK_W-1:0] zero count
busy  output  1  high in REQ, WAIT, CHECK
done  output  1  one-cycle pulse at end of a completed pass
err_valid  output  1  one-cycle pulse per failing word
err_addr  output  ADDR_W  address of last failing word; held until next error
err_count  output  CNT_W  failing words this pass; saturates at all-ones

Behaviour:
- Reset: state IDLE; mem_req=0, mem_addr=0, busy=0, done=0, err_valid=0, err_addr=0, err_count=0.
- States: IDLE, REQ, WAIT, CHECK, DONE.
- IDLE: start=1 -> REQ next cycle; mem_addr=0, err_count cleared to 0. err_addr is not cleared.
- REQ: mem_req=1 held at a stable mem_addr. mem_gnt=1 -> WAIT next cycle, mem_req drops. A mem_rvalid seen in REQ is ignored.
- WAIT: mem_req=0. mem_rvalid=1 -> capture mem_rdata into an internal register -> CHECK.
- CHECK: zeros = DATA_W minus popcount(data field), computed in CHK_W bits.
  - If zeros != check field: err_valid=1 for this cycle, err_addr=mem_addr, err_count increments unless it is all-ones.
  - If mem_addr==DEPTH-1 -> DONE; otherwise mem_addr+1 -> REQ.
- DONE: done=1 for one cycle -> IDLE. mem_addr stays at DEPTH-1 until the next start.
- err_valid and done are registered outputs, asserted only in the states named above.
- Throughput: 3 cycles per word with same-cycle grant and 1-cycle read latency. Full default pass = 1 (start->REQ) + 192 + 1 (DONE) cycles.
- abort=1 in any state -> IDLE next cycle:
  - mem_req deasserts; no done pulse; err_count is held.
  - A late mem_rvalid arriving in IDLE is ignored.
  - abort takes priority over start in the same cycle.
- start while busy or in DONE: ignored, no effect.
- Reset asserted mid-pass: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: BERGER_SCRUB_HALT_ON_ERR_EN.
- Defined:
  - On the first failing word, CHECK -> DONE regardless of address.
  - done pulses; mem_addr and err_addr both hold the failing address; err_count=1.
- Undefined: the scan always completes all DEPTH words.

Test Plan:
- Clean memory, every word correct (e.g. data 0xA5 -> code 0xA54; 0xFF -> 0xFF0; 0x00 -> 0x008), grant always 1, 1-cycle read -> 64 reads at addresses 0..63, err_valid never high, err_count=0, done pulses exactly 194 cycles after start.
- Address 5 = 0xA55, address 40 = 0x001, others clean -> err_valid pulses twice, err_addr=5 then 40, err_count=2, done pulses once.
- Grant withheld 4 cycles at address 3 -> mem_req held high with mem_addr=3 for 5 cycles, no duplicate read, pass still completes with err_count=0.
- abort asserted while in WAIT at address 10 -> next cycle busy=0, mem_req=0, no done. A following mem_rvalid is ignored; err_count unchanged.
- 300 corrupted words with ADDR_W=9 and CNT_W=8 -> err_count stops at 255 and does not wrap. Second start -> err_count cleared to 0.
- With BERGER_SCRUB_HALT_ON_ERR_EN, error at address 7 -> done pulses after CHECK of address 7, err_addr=7, no read issued for address 8.
